vram_ctrl: RTL and testbench
============================

VRAM_CTRL -- requirements
Module: vram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width; memory depth 2**ADDR_W words.
REQ-002 SHALL have parameter BYTES, default 2, bytes per word; data width DW = 8*BYTES.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, video prefetch FIFO entries, power of two, >= 4.
REQ-004 SHALL have parameter FRAME_WORDS, default 512, words fetched per frame.
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-008 SHALL have port cpu_we  in  1  1 = write, 0 = read.
REQ-009 SHALL have port cpu_addr  in  ADDR_W  CPU word address.
REQ-010 SHALL have port cpu_be  in  BYTES  per-byte write enables.
REQ-011 SHALL have port cpu_wdata  in  DW  write data.
REQ-012 SHALL have port cpu_ack  out  1  one-cycle completion pulse.
REQ-013 SHALL have port cpu_rdata  out  DW  read data, valid while cpu_ack=1.
REQ-014 SHALL have port vid_start  in  1  frame-start pulse.
REQ-015 SHALL have port vid_base  in  ADDR_W  frame start word address, sampled on vid_start.
REQ-016 SHALL have port vid_pop  in  1  consume FIFO head.
REQ-017 SHALL have port vid_data  out  DW  FIFO head word.
REQ-018 SHALL have port vid_empty  out  1  FIFO empty.
REQ-019 SHALL have port vid_underrun  out  1  sticky pop-while-empty flag.

Function
REQ-020 SHALL contain one inferred single-port synchronous RAM, one access per cycle, 1-cycle read latency; contents not reset.
REQ-021 SHALL run video FSM states V_IDLE, V_RUN; vid_start in any state -> V_RUN, fetch address := vid_base, fetched count := 0, FIFO flushed, in-flight read discarded.
REQ-022 SHALL in V_RUN leave for V_IDLE once FRAME_WORDS reads have been issued; fetch address increments by 1, wrapping modulo 2**ADDR_W.
REQ-023 SHALL define occ = FIFO count + in-flight video reads; video fetch eligible only in V_RUN with occ < FIFO_DEPTH.
REQ-024 SHALL arbitrate per cycle: video if eligible and occ < FIFO_DEPTH/2 (urgent); else CPU if cpu_req and no cpu_ack this cycle; else video if eligible; else idle.
REQ-025 SHALL for a CPU grant in cycle N perform the access in N and assert cpu_ack in N+1; cpu_rdata = RAM word on reads, unchanged on writes.
REQ-026 SHALL not grant the CPU in a cycle where cpu_ack=1 (max one CPU access per 2 cycles).
REQ-027 SHALL for a video read issued in cycle N push data into the FIFO at end of N+1.
REQ-028 SHALL on simultaneous push and pop keep count unchanged; head advances.
REQ-029 SHALL ignore vid_pop when empty and set vid_underrun; cleared only by rst or vid_start.
REQ-030 SHALL drive vid_data to 0 while empty.
REQ-031 SHALL, with vid_pop held 0 and FIFO full, ack a CPU request within 2 cycles of assertion.

Reset
REQ-032 SHALL on rst=1 at clock edge set cpu_ack=0, cpu_rdata=0, vid_empty=1, vid_underrun=0, vid_data=0, FSM=V_IDLE, FIFO count=0, in-flight cleared.
REQ-033 SHALL abort a CPU access granted in the cycle rst is asserted: no cpu_ack issued; a write already committed in that cycle remains.
REQ-034 SHALL have rst priority over vid_start and cpu_req.

Configuration
REQ-035 SHALL, with macro VRAM_CTRL_BYTE_WRITE_EN defined, write only bytes whose cpu_be bit is 1.
REQ-036 SHALL, without VRAM_CTRL_BYTE_WRITE_EN, ignore cpu_be and write full words.

Verification
REQ-037 SHALL cover: write addr 0x010 data 0xBEEF be=11, then read 0x010 -> cpu_ack 1 cycle after each grant, cpu_rdata=0xBEEF.
REQ-038 SHALL cover (macro on): write 0x1234 to 0x020, then 0xAB55 be=01 -> read gives 0x1255; macro off -> 0xAB55.
REQ-039 SHALL cover: preload words 0x3FE..0x001 = 1..4, vid_base=0x3FE, vid_start, pop 4 -> vid_data 1,2,3,4, address wraps 0x3FF->0x000.
REQ-040 SHALL cover: vid_start, no pops -> FIFO fills to 4, vid_empty=0, no further fetch; CPU read acked within 2 cycles.
REQ-041 SHALL cover: pop on empty FIFO after reset -> vid_underrun=1, stays 1 until vid_start.
REQ-042 SHALL cover: vid_start mid-frame with read in flight -> FIFO flushed, first popped word = RAM[new vid_base].

Source files
------------

// File: rtl/vram_ctrl.sv
// Video RAM controller: one single-port RAM shared by a CPU port and a video prefetch FIFO.
// Optional per-byte CPU write enables when VRAM_CTRL_BYTE_WRITE_EN is defined.
module vram_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int BYTES       = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [BYTES-1:0]     cpu_be,
  input  logic [8*BYTES-1:0]   cpu_wdata,
  output logic                 cpu_ack,
  output logic [8*BYTES-1:0]   cpu_rdata,
  input  logic                 vid_start,
  input  logic [ADDR_W-1:0]    vid_base,
  input  logic                 vid_pop,
  output logic [8*BYTES-1:0]   vid_data,
  output logic                 vid_empty,
  output logic                 vid_underrun
);

  localparam int DW = 8 * BYTES;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FRAME_WORDS + 1);

  typedef enum logic { V_IDLE, V_RUN } vstate_t;

  vstate_t             r_vstate;
  logic [DW-1:0]       r_mem [2**ADDR_W];
  logic [DW-1:0]       r_ram_q;
  logic [DW-1:0]       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_cnt;
  logic                r_vid_inflight;
  logic [ADDR_W-1:0]   r_vaddr;
  logic [FW-1:0]       r_fetched;
  logic                r_cpu_ack;
  logic                r_cpu_rd_pend;
  logic [DW-1:0]       r_cpu_hold;
  logic                r_underrun;

  logic [CW-1:0]       w_occ;
  logic                w_vid_elig;
  logic                w_vid_urgent;
  logic                w_cpu_gnt;
  logic                w_vid_gnt;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic                w_ram_we;
  logic [BYTES-1:0]    w_be_mask;
  logic                w_push;
  logic                w_pop;

`ifdef VRAM_CTRL_BYTE_WRITE_EN
  assign w_be_mask = cpu_be;
`else
  assign w_be_mask = cpu_be | {BYTES{1'b1}};
`endif

  // A vid_start cycle issues no video read: anything fetched now would belong to the old frame.
  assign w_occ        = r_cnt + CW'(r_vid_inflight);
  assign w_vid_elig   = (r_vstate == V_RUN) && !vid_start && (w_occ < CW'(FIFO_DEPTH));
  assign w_vid_urgent = w_vid_elig && (w_occ < CW'(FIFO_DEPTH / 2));
  assign w_cpu_gnt    = !w_vid_urgent && cpu_req && !r_cpu_ack;
  assign w_vid_gnt    = w_vid_elig && !w_cpu_gnt;
  assign w_ram_addr   = w_cpu_gnt ? cpu_addr : r_vaddr;
  assign w_ram_we     = w_cpu_gnt && cpu_we;
  assign w_push       = r_vid_inflight;
  assign w_pop        = vid_pop && (r_cnt != '0);

  // Write is not gated by rst so a write granted in the reset cycle still lands.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (w_ram_we && w_be_mask[b]) begin
        r_mem[w_ram_addr][8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
    end
    r_ram_q <= r_mem[w_ram_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vstate       <= V_IDLE;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_cnt          <= '0;
      r_vid_inflight <= 1'b0;
      r_vaddr        <= '0;
      r_fetched      <= '0;
      r_cpu_ack      <= 1'b0;
      r_cpu_rd_pend  <= 1'b0;
      r_cpu_hold     <= '0;
      r_underrun     <= 1'b0;
    end else begin
      r_cpu_ack     <= w_cpu_gnt;
      r_cpu_rd_pend <= w_cpu_gnt && !cpu_we;
      if (r_cpu_ack && r_cpu_rd_pend) begin
        r_cpu_hold <= r_ram_q;
      end

      if (vid_start) begin
        r_vstate       <= V_RUN;
        r_vaddr        <= vid_base;
        r_fetched      <= '0;
        r_wptr         <= '0;
        r_rptr         <= '0;
        r_cnt          <= '0;
        r_vid_inflight <= 1'b0;
        r_underrun     <= 1'b0;
      end else begin
        r_vid_inflight <= w_vid_gnt;
        if (w_vid_gnt) begin
          r_vaddr   <= r_vaddr + ADDR_W'(1);
          r_fetched <= r_fetched + FW'(1);
          if (r_fetched == FW'(FRAME_WORDS - 1)) begin
            r_vstate <= V_IDLE;
          end
        end
        // Occupancy accounting guarantees a push never meets a full FIFO.
        if (w_push) begin
          r_fifo[r_wptr] <= r_ram_q;
          r_wptr         <= r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PW'(1);
        end
        if (vid_pop && (r_cnt == '0)) begin
          r_underrun <= 1'b1;
        end
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign cpu_ack      = r_cpu_ack;
  assign cpu_rdata    = (r_cpu_ack && r_cpu_rd_pend) ? r_ram_q : r_cpu_hold;
  assign vid_empty    = (r_cnt == '0);
  assign vid_data     = (r_cnt == '0) ? '0 : r_fifo[r_rptr];
  assign vid_underrun = r_underrun;

endmodule

// File: tb/tb_vram_ctrl.sv
// Self-checking bench for vram_ctrl: CPU accesses, byte writes, video prefetch, underrun, restart.
module tb_vram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        vid_start;
  logic [9:0]  vid_base;
  logic        vid_pop;
  logic [15:0] vid_data;
  logic        vid_empty;
  logic        vid_underrun;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_mem [0:1023];
  logic [15:0] cpu_q [$];
  logic [15:0] vid_q [$];
  logic [15:0] last_rd;

  vram_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_start(vid_start), .vid_base(vid_base), .vid_pop(vid_pop),
    .vid_data(vid_data), .vid_empty(vid_empty), .vid_underrun(vid_underrun)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_access(input logic we, input logic [9:0] addr, input logic [1:0] be,
                            input logic [15:0] wd, output int lat);
    int n;
    bit got;
    logic [15:0] exp;
    if (we) begin
`ifdef VRAM_CTRL_BYTE_WRITE_EN
      for (int b = 0; b < 2; b++) if (be[b]) m_mem[addr][8*b +: 8] = wd[8*b +: 8];
`else
      m_mem[addr] = wd;
`endif
    end else begin
      cpu_q.push_back(m_mem[addr]);
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      step(1);
      n++;
      if (cpu_ack) got = 1'b1;
    end
    cpu_req = 1'b0;
    lat = n;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL cpu_ack_timeout addr=%h: no ack after %0d cycles", addr, n);
      if (!we) exp = cpu_q.pop_front();
    end else if (!we) begin
      exp = cpu_q.pop_front();
      if (cpu_rdata !== exp) begin
        errors++;
        $display("FAIL cpu_rdata addr=%h: got %h expected %h", addr, cpu_rdata, exp);
      end
      last_rd = exp;
    end else if (cpu_rdata !== last_rd) begin
      errors++;
      $display("FAIL rdata_held_on_write addr=%h: got %h expected %h", addr, cpu_rdata, last_rd);
    end
    step(1);
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_single_pulse addr=%h: got %b expected 0", addr, cpu_ack);
    end
  endtask

  task automatic vid_begin(input logic [9:0] base, input int n);
    logic [9:0] a;
    vid_base = base;
    vid_start = 1'b1;
    step(1);
    vid_start = 1'b0;
    vid_q.delete();
    for (int i = 0; i < n; i++) begin
      a = base + 10'(i);
      vid_q.push_back(m_mem[a]);
    end
  endtask

  task automatic vid_pop_check(input string name);
    int n;
    logic [15:0] exp;
    n = 0;
    while (vid_empty && n < 20) begin
      step(1);
      n++;
    end
    exp = vid_q.pop_front();
    checks++;
    if (vid_empty) begin
      errors++;
      $display("FAIL %s_timeout: FIFO still empty after %0d cycles, expected %h", name, n, exp);
    end else if (vid_data !== exp) begin
      errors++;
      $display("FAIL %s: vid_data got %h expected %h", name, vid_data, exp);
    end
    vid_pop = 1'b1;
    step(1);
    vid_pop = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    step(3);
    checks++;
    if ({cpu_ack, cpu_rdata, vid_empty, vid_underrun, vid_data} !== {1'b0, 16'h0, 1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b rdata=%h empty=%b underrun=%b vdata=%h expected 0/0000/1/0/0000",
               cpu_ack, cpu_rdata, vid_empty, vid_underrun, vid_data);
    end
    // Write granted while rst is high: no ack, data still committed.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h030; cpu_be = 2'b11; cpu_wdata = 16'h5A5A;
    step(1);
    cpu_req = 1'b0;
    rst = 1'b0;
    m_mem[10'h030] = 16'h5A5A;
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_ack: got %b expected 0", cpu_ack);
    end
    step(1);
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_ack_late: got %b expected 0", cpu_ack);
    end
    last_rd = 16'h0;
    cpu_access(1'b0, 10'h030, 2'b11, 16'h0, lat);
  endtask

  task automatic test_underrun();
    checks++;
    if (vid_empty !== 1'b1 || vid_data !== 16'h0) begin
      errors++;
      $display("FAIL empty_data: empty=%b data=%h expected 1/0000", vid_empty, vid_data);
    end
    vid_pop = 1'b1;
    step(1);
    vid_pop = 1'b0;
    checks++;
    if (vid_underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set: got %b expected 1", vid_underrun);
    end
    step(4);
    checks++;
    if (vid_underrun !== 1'b1 || vid_empty !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky: underrun=%b empty=%b expected 1/1", vid_underrun, vid_empty);
    end
    vid_begin(10'h000, 0);
    checks++;
    if (vid_underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: got %b expected 0", vid_underrun);
    end
    step(10);
  endtask

  task automatic test_cpu_rw();
    int lat;
    logic [15:0] pat [3];
    pat[0] = 16'hBEEF; pat[1] = 16'h0000; pat[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      cpu_access(1'b1, 10'h010 + 10'(i), 2'b11, pat[i], lat);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL write_latency[%0d]: got %0d cycles expected 1", i, lat);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cpu_access(1'b0, 10'h010 + 10'(i), 2'b11, 16'h0, lat);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL read_latency[%0d]: got %0d cycles expected 1", i, lat);
      end
    end
  endtask

  task automatic test_byte_write();
    int lat;
    cpu_access(1'b1, 10'h020, 2'b11, 16'h1234, lat);
    cpu_access(1'b1, 10'h020, 2'b01, 16'hAB55, lat);
    cpu_access(1'b0, 10'h020, 2'b11, 16'h0, lat);
    cpu_access(1'b1, 10'h021, 2'b11, 16'h1234, lat);
    cpu_access(1'b1, 10'h021, 2'b10, 16'hAB55, lat);
    cpu_access(1'b0, 10'h021, 2'b11, 16'h0, lat);
  endtask

  task automatic test_wrap();
    int lat;
    logic [9:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 10'h3FE + 10'(i);
      cpu_access(1'b1, a, 2'b11, 16'(i + 1), lat);
    end
    vid_begin(10'h3FE, 4);
    for (int i = 0; i < 4; i++) vid_pop_check("wrap_pop");
  endtask

  task automatic test_fill_cpu();
    int lat;
    for (int i = 0; i < 6; i++) cpu_access(1'b1, 10'h100 + 10'(i), 2'b11, 16'hA000 + 16'(i), lat);
    vid_begin(10'h100, 6);
    step(10);
    checks++;
    if (vid_empty !== 1'b0) begin
      errors++;
      $display("FAIL fill_not_empty: got %b expected 0", vid_empty);
    end
    cpu_access(1'b0, 10'h010, 2'b11, 16'h0, lat);
    checks++;
    if (lat > 2) begin
      errors++;
      $display("FAIL fill_cpu_latency: got %0d cycles expected <= 2", lat);
    end
    for (int i = 0; i < 6; i++) vid_pop_check("fill_pop");
  endtask

  task automatic test_restart();
    int lat;
    cpu_access(1'b1, 10'h200, 2'b11, 16'h1111, lat);
    cpu_access(1'b1, 10'h201, 2'b11, 16'h2222, lat);
    cpu_access(1'b1, 10'h300, 2'b11, 16'h3333, lat);
    cpu_access(1'b1, 10'h301, 2'b11, 16'h4444, lat);
    vid_begin(10'h200, 0);
    step(1);
    vid_begin(10'h300, 2);
    checks++;
    if (vid_empty !== 1'b1) begin
      errors++;
      $display("FAIL restart_flush: empty got %b expected 1", vid_empty);
    end
    vid_pop_check("restart_pop");
    vid_pop_check("restart_pop");
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    vid_start = 1'b0; vid_base = '0; vid_pop = 1'b0; last_rd = '0;
    for (int i = 0; i < 1024; i++) m_mem[i] = 16'h0;
    #1;
    test_reset();
    test_underrun();
    test_cpu_rw();
    test_byte_write();
    test_wrap();
    test_fill_cpu();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
